// File: rtl/avalon_mem_arbiter_pkg.sv
// Shared types and helpers for the two-master Avalon-MM memory arbiter.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_GNT0 = 2'd1,
    ARB_GNT1 = 2'd2
  } arb_state_t;

  localparam int M0_IDX = 0;
  localparam int M1_IDX = 1;

  // Stall counter width; kept at least 1 bit so a disabled (0) limit still elaborates.
  function automatic int cnt_width(input int cycles);
    return (cycles < 1) ? 1 : $clog2(cycles + 1);
  endfunction

endpackage

// File: rtl/avalon_mem_arbiter_timer.sv
// Saturating stall counter with a sticky overflow flag for one granted transfer.
module arb_stall_timer #(
  parameter int CNT_W = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             stall,
  input  logic [CNT_W-1:0] limit,
  output logic             err
);

  logic [CNT_W-1:0] r_cnt;
  logic             r_err;
  logic [CNT_W-1:0] w_cnt_inc;
  logic             w_inc_en;

  assign w_cnt_inc = r_cnt + 1'b1;
  // Counter stops at the limit; a zero limit means it never moves and never flags.
  assign w_inc_en  = stall && !clear && (r_cnt != limit);
  assign err       = r_err;

  // Count stalled cycles; the flag is set on the edge where the count reaches the limit.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt <= '0;
      r_err <= 1'b0;
    end else begin
      if (clear)         r_cnt <= '0;
      else if (w_inc_en) r_cnt <= w_cnt_inc;
      if (w_inc_en && (limit != '0) && (w_cnt_inc == limit)) r_err <= 1'b1;
    end
  end

endmodule

// File: rtl/avalon_mem_arbiter.sv
// Round-robin arbiter sharing one Avalon-MM RAM slave between instruction fetch (M0)
// and data load/store (M1). Grant is held until the transfer completes or is abandoned.
module avalon_mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W         = 32,
  parameter int DATA_W         = 32,
  parameter int TIMEOUT_CYCLES = 1000
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [ADDR_W-1:0]   m0_address,
  input  logic                m0_read,
  input  logic                m0_write,
  input  logic [DATA_W-1:0]   m0_writedata,
  input  logic [DATA_W/8-1:0] m0_byteenable,
  output logic                m0_waitrequest,
  output logic [DATA_W-1:0]   m0_readdata,
  input  logic [ADDR_W-1:0]   m1_address,
  input  logic                m1_read,
  input  logic                m1_write,
  input  logic [DATA_W-1:0]   m1_writedata,
  input  logic [DATA_W/8-1:0] m1_byteenable,
  output logic                m1_waitrequest,
  output logic [DATA_W-1:0]   m1_readdata,
  output logic [ADDR_W-1:0]   s_address,
  output logic                s_read,
  output logic                s_write,
  output logic [DATA_W-1:0]   s_writedata,
  output logic [DATA_W/8-1:0] s_byteenable,
  input  logic                s_waitrequest,
  input  logic [DATA_W-1:0]   s_readdata,
  output logic [1:0]          grant,
  output logic                timeout_err
);

  localparam int               CNT_W = cnt_width(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT_CYCLES);
  localparam logic             OWN_M0 = 1'(M0_IDX);
  localparam logic             OWN_M1 = 1'(M1_IDX);

  arb_state_t r_state;
  logic       r_last_owner;

  logic w_req0, w_req1, w_gnt0, w_gnt1, w_stall, w_tmr_clear;

  assign w_req0 = m0_read | m0_write;
  assign w_req1 = m1_read | m1_write;
  assign w_gnt0 = (r_state == ARB_GNT0);
  assign w_gnt1 = (r_state == ARB_GNT1);

  assign grant[M0_IDX] = w_gnt0;
  assign grant[M1_IDX] = w_gnt1;

  assign m0_readdata = s_readdata;
  assign m1_readdata = s_readdata;

  // A granted cycle without waitrequest always leaves the grant (completion or
  // abandon), so clearing on every non-stall cycle gives a zero count on each entry.
  assign w_stall     = (w_gnt0 | w_gnt1) & s_waitrequest;
  assign w_tmr_clear = ~w_stall;

  // Arbitration FSM: round-robin on collision, grant held until completion or abandon.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= ARB_IDLE;
      r_last_owner <= OWN_M1;
    end else begin
      case (r_state)
        ARB_IDLE: begin
          if (w_req0 && (!w_req1 || r_last_owner == OWN_M1)) r_state <= ARB_GNT0;
          else if (w_req1)                                   r_state <= ARB_GNT1;
        end
        ARB_GNT0: begin
          if (!w_req0) begin
            r_state      <= ARB_IDLE;
            r_last_owner <= OWN_M0;
          end else if (!s_waitrequest) begin
            r_state      <= w_req1 ? ARB_GNT1 : ARB_IDLE;
            r_last_owner <= OWN_M0;
          end
        end
        ARB_GNT1: begin
          if (!w_req1) begin
            r_state      <= ARB_IDLE;
            r_last_owner <= OWN_M1;
          end else if (!s_waitrequest) begin
            r_state      <= w_req0 ? ARB_GNT0 : ARB_IDLE;
            r_last_owner <= OWN_M1;
          end
        end
        default: r_state <= ARB_IDLE;
      endcase
    end
  end

  // Slave-side mux driven only by state and master inputs, never by s_waitrequest.
  always_comb begin
    s_address      = '0;
    s_read         = 1'b0;
    s_write        = 1'b0;
    s_writedata    = '0;
    s_byteenable   = '0;
    m0_waitrequest = 1'b1;
    m1_waitrequest = 1'b1;
    case (r_state)
      ARB_GNT0: begin
        s_address      = m0_address;
        s_read         = m0_read;
        s_write        = m0_write;
        s_writedata    = m0_writedata;
        s_byteenable   = m0_byteenable;
        m0_waitrequest = s_waitrequest;
      end
      ARB_GNT1: begin
        s_address      = m1_address;
        s_read         = m1_read;
        s_write        = m1_write;
        s_writedata    = m1_writedata;
        s_byteenable   = m1_byteenable;
        m1_waitrequest = s_waitrequest;
      end
      default: ;
    endcase
  end

  arb_stall_timer #(.CNT_W(CNT_W)) u_timer (
    .clk   (clk),
    .reset (reset),
    .clear (w_tmr_clear),
    .stall (w_stall),
    .limit (LIMIT),
    .err   (timeout_err)
  );

endmodule
